// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg
//   Shared types and constants for the reset sequencer slice.
//   state_t : FSM encoding (HOLD=0, STAGE=1, RUN=2)
//   EVT_W   : width of the saturating re-reset event counter
package reset_seq_pkg;

  localparam int EVT_W = 8;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    STAGE = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/reset_req_sync.sv
// reset_req_sync
//   Multi-flop bit synchroniser for one asynchronous reset-request level.
//   clk : sampling clock
//   rst : synchronous, active-high clear of every stage
//   d   : asynchronous input level
//   q   : synchronised level, STAGES edges after d
module reset_req_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
    end
  end

  assign q = sync[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Multi-channel reset generator. Holds all active-low outputs low for
//   HOLD_CYCLES cycles, then releases channel 0..NCH-1 one at a time,
//   STAGE_GAP cycles apart. Any request re-enters the hold.
//   CLK       : sole clock
//   RST       : synchronous, active-high reset
//   REQ       : asynchronous reset-request levels (synchronised here)
//   SW_REQ    : CLK-domain single-cycle reset request
//   OUT_RST_N : sequenced active-low resets, bit k released k-th
//   DONE      : all channels released
//   EVENT_CNT : saturating count of requests taken outside HOLD
//
//   state | meaning
//   HOLD  | all outputs low, counting out the hold time
//   STAGE | releasing channels one per STAGE_GAP cycles
//   RUN   | all outputs released, DONE high, waiting for a request
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int CNT_W       = 8,
  parameter int NREQ        = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NREQ-1:0]  REQ,
  input  logic             SW_REQ,
  output logic [NCH-1:0]   OUT_RST_N,
  output logic             DONE,
  output logic [EVT_W-1:0] EVENT_CNT
);

  if (NCH < 1) begin : g_chk_nch
    $error("reset_sequencer: NCH must be >= 1");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES >= 2**CNT_W) begin : g_chk_hold
    $error("reset_sequencer: HOLD_CYCLES must be in [1, 2**CNT_W)");
  end
  if (STAGE_GAP < 1 || STAGE_GAP >= 2**CNT_W) begin : g_chk_gap
    $error("reset_sequencer: STAGE_GAP must be in [1, 2**CNT_W)");
  end
  if (NREQ < 1) begin : g_chk_nreq
    $error("reset_sequencer: NREQ must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("reset_sequencer: SYNC_STAGES must be >= 2");
  end

  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

  logic [NREQ-1:0] req_sync;
  logic            req;

  for (genvar i = 0; i < NREQ; i++) begin : g_sync
    reset_req_sync #(
      .STAGES(SYNC_STAGES)
    ) u_sync (
      .clk(CLK),
      .rst(RST),
      .d  (REQ[i]),
      .q  (req_sync[i])
    );
  end

  assign req = (|req_sync) | SW_REQ;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NCH-1:0]     out_q, out_d;
  logic [EVT_W-1:0]   evt_q, evt_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      evt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      evt_q   <= evt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    out_d   = out_q;
    evt_d   = evt_q;

    if (req) begin
      // A request wins over any release that falls due on the same edge,
      // and a held request keeps the hold counter parked at zero.
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      out_d   = '0;
      if (state_q != HOLD && evt_q != '1) begin
        evt_d = evt_q + 1'b1;
      end
    end else begin
      case (state_q)
        HOLD: begin
          out_d = '0;
          if (cnt_q == HOLD_LAST) begin
            out_d[0] = 1'b1;
            cnt_d    = '0;
            idx_d    = '0;
            state_d  = (NCH == 1) ? RUN : STAGE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STAGE: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 1'b1;
            for (int k = 1; k < NCH; k++) begin
              if (k == int'(idx_q) + 1) begin
                out_d[k] = 1'b1;
              end
            end
            if (int'(idx_q) == NCH - 2) begin
              state_d = RUN;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          out_d = '1;
        end
        default: begin
          state_d = HOLD;
          cnt_d   = '0;
          idx_d   = '0;
          out_d   = '0;
        end
      endcase
    end
  end

  assign OUT_RST_N = out_q;
  assign DONE      = (state_q == RUN);
  assign EVENT_CNT = evt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  localparam int HOLD = 16;
  localparam int GAP  = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic [1:0] REQ;
  logic       SW_REQ;
  logic [3:0] OUT_RST_N;
  logic       DONE;
  logic [7:0] EVENT_CNT;

  logic       s_rst;
  logic [1:0] s_req;
  logic       s_sw_req;
  logic [0:0] s_out;
  logic       s_done;
  logic [7:0] s_evt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] out;
    logic       done;
    logic [7:0] evt;
  } exp_t;

  exp_t sbq[$];

  always #5 CLK = ~CLK;

  reset_sequencer #(
    .NCH(4), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP),
    .CNT_W(8), .NREQ(2), .SYNC_STAGES(2)
  ) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .SW_REQ(SW_REQ),
    .OUT_RST_N(OUT_RST_N), .DONE(DONE), .EVENT_CNT(EVENT_CNT)
  );

  reset_sequencer #(
    .NCH(1), .HOLD_CYCLES(1), .STAGE_GAP(1),
    .CNT_W(8), .NREQ(2), .SYNC_STAGES(2)
  ) dut_small (
    .CLK(CLK), .RST(s_rst), .REQ(s_req), .SW_REQ(s_sw_req),
    .OUT_RST_N(s_out), .DONE(s_done), .EVENT_CNT(s_evt)
  );

  // r = edge number within a sequence, edge 1 being the first hold edge.
  function automatic void push_seq(int r, logic [7:0] evt);
    exp_t x;
    x.out = '0;
    for (int k = 0; k < 4; k++) begin
      if (r >= HOLD + k * GAP) x.out[k] = 1'b1;
    end
    x.done = (r >= HOLD + 3 * GAP);
    x.evt  = evt;
    sbq.push_back(x);
  endfunction

  function automatic void push_const(logic [3:0] out, logic done, logic [7:0] evt);
    exp_t x;
    x.out  = out;
    x.done = done;
    x.evt  = evt;
    sbq.push_back(x);
  endfunction

  task automatic test_reset();
    exp_t x;
    RST = 1'b1;
    for (int e = 1; e <= 3; e++) push_const(4'b0000, 1'b0, 8'd0);
    for (int e = 1; e <= 3; e++) push_seq(e, 8'd0);
    for (int e = 1; e <= 35; e++) begin
      if (e == 4) begin
        RST = 1'b0;
        for (int r = 4; r <= 32; r++) push_seq(r, 8'd0);
      end
      if (e >= 4) begin
        @(posedge CLK); #1;
      end else begin
        @(posedge CLK); #1;
      end
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL reset e=%0d: scoreboard empty", e);
      end else begin
        x = sbq.pop_front();
        if ({OUT_RST_N, DONE, EVENT_CNT} !== {x.out, x.done, x.evt}) begin
          errors++;
          $display("FAIL reset e=%0d: got out=%b done=%b evt=%0d, want out=%b done=%b evt=%0d",
                   e, OUT_RST_N, DONE, EVENT_CNT, x.out, x.done, x.evt);
        end
      end
    end
  endtask

  task automatic test_sw_req();
    exp_t x;
    push_const(4'b0000, 1'b0, 8'd1);
    for (int e = 2; e <= 32; e++) push_seq(e - 1, 8'd1);
    SW_REQ = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      @(posedge CLK); #1;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sw_req e=%0d: scoreboard empty", e);
      end else begin
        x = sbq.pop_front();
        if ({OUT_RST_N, DONE, EVENT_CNT} !== {x.out, x.done, x.evt}) begin
          errors++;
          $display("FAIL sw_req e=%0d: got out=%b done=%b evt=%0d, want out=%b done=%b evt=%0d",
                   e, OUT_RST_N, DONE, EVENT_CNT, x.out, x.done, x.evt);
        end
      end
      if (e == 1) SW_REQ = 1'b0;
    end
  endtask

  task automatic test_async_req();
    exp_t x;
    RST = 1'b1;
    push_const(4'b0000, 1'b0, 8'd0);
    for (int e = 1; e <= 23; e++) push_seq(e, 8'd0);
    for (int e = 24; e <= 33; e++) push_const(4'b0000, 1'b0, 8'd1);
    for (int e = 34; e <= 64; e++) push_seq(e - 33, 8'd1);
    for (int e = 0; e <= 64; e++) begin
      @(posedge CLK); #1;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL async_req e=%0d: scoreboard empty", e);
      end else begin
        x = sbq.pop_front();
        if ({OUT_RST_N, DONE, EVENT_CNT} !== {x.out, x.done, x.evt}) begin
          errors++;
          $display("FAIL async_req e=%0d: got out=%b done=%b evt=%0d, want out=%b done=%b evt=%0d",
                   e, OUT_RST_N, DONE, EVENT_CNT, x.out, x.done, x.evt);
        end
      end
      if (e == 0)  RST = 1'b0;
      if (e == 21) REQ = 2'b10;
      if (e == 31) REQ = 2'b00;
    end
  endtask

  task automatic test_mid_reset();
    exp_t x;
    push_const(4'b0000, 1'b0, 8'd2);
    for (int e = 2; e <= 22; e++) push_seq(e - 1, 8'd2);
    push_const(4'b0000, 1'b0, 8'd0);
    for (int e = 24; e <= 54; e++) push_seq(e - 23, 8'd0);
    SW_REQ = 1'b1;
    for (int e = 1; e <= 54; e++) begin
      @(posedge CLK); #1;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL mid_reset e=%0d: scoreboard empty", e);
      end else begin
        x = sbq.pop_front();
        if ({OUT_RST_N, DONE, EVENT_CNT} !== {x.out, x.done, x.evt}) begin
          errors++;
          $display("FAIL mid_reset e=%0d: got out=%b done=%b evt=%0d, want out=%b done=%b evt=%0d",
                   e, OUT_RST_N, DONE, EVENT_CNT, x.out, x.done, x.evt);
        end
      end
      if (e == 1)  SW_REQ = 1'b0;
      if (e == 22) RST = 1'b1;
      if (e == 23) RST = 1'b0;
    end
  endtask

  task automatic test_single_channel();
    exp_t x;
    s_rst = 1'b1;
    push_const(4'b0000, 1'b0, 8'd0);
    push_const(4'b0001, 1'b1, 8'd0);
    push_const(4'b0001, 1'b1, 8'd0);
    push_const(4'b0000, 1'b0, 8'd1);
    push_const(4'b0001, 1'b1, 8'd1);
    for (int e = 0; e <= 4; e++) begin
      @(posedge CLK); #1;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL single_ch e=%0d: scoreboard empty", e);
      end else begin
        x = sbq.pop_front();
        if ({3'b000, s_out, s_done, s_evt} !== {x.out, x.done, x.evt}) begin
          errors++;
          $display("FAIL single_ch e=%0d: got out=%b done=%b evt=%0d, want out=%b done=%b evt=%0d",
                   e, s_out, s_done, s_evt, x.out[0], x.done, x.evt);
        end
      end
      if (e == 0) s_rst = 1'b0;
      if (e == 2) s_sw_req = 1'b1;
      if (e == 3) s_sw_req = 1'b0;
    end
  endtask

  task automatic test_saturation();
    exp_t x;
    for (int i = 1; i <= 301; i++) begin
      if (i <= 300) begin
        SW_REQ = 1'b1;
        push_const(4'b0000, 1'b0, (i > 255) ? 8'd255 : 8'(i));
      end else begin
        RST = 1'b1;
        push_const(4'b0000, 1'b0, 8'd0);
      end
      @(posedge CLK); #1;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL saturate i=%0d: scoreboard empty", i);
      end else begin
        x = sbq.pop_front();
        if ({OUT_RST_N, DONE, EVENT_CNT} !== {x.out, x.done, x.evt}) begin
          errors++;
          $display("FAIL saturate i=%0d: got out=%b done=%b evt=%0d, want out=%b done=%b evt=%0d",
                   i, OUT_RST_N, DONE, EVENT_CNT, x.out, x.done, x.evt);
        end
      end
      SW_REQ = 1'b0;
      RST    = 1'b0;
      if (i <= 300) repeat (39) @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    RST      = 1'b1;
    REQ      = 2'b00;
    SW_REQ   = 1'b0;
    s_rst    = 1'b1;
    s_req    = 2'b00;
    s_sw_req = 1'b0;
    #1;
    test_reset();
    test_sw_req();
    test_async_req();
    test_mid_reset();
    test_single_channel();
    test_saturation();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d queued entries, want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
